shared_reg_arbiter: RTL and testbench

- Round-robin write arbiter for one shared 8-bit register (a dff_8bit instance) that NUM_REQ requesters can write.
- Picks one requester per cycle, forwards that requester's data, and drives the register's en/in pins.
- Supports bounded locked bursts, so one requester can make several back-to-back writes without being preempted.
- Sits between the requesting units and the register; the register output is read directly by consumers, not through this block.

---
 rtl/shared_reg_arbiter_if.sv | 40 ++++
 rtl/shared_reg_arbiter.sv | 146 ++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Write-request bus between requesting units and the shared register arbiter.
interface shared_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic                     reg_en;
  logic [WIDTH-1:0]         reg_in;
  logic                     busy;

  // Requester side: drives requests and data, observes grants and register pins.
  modport master (
    output req,
    output lock,
    output wdata,
    input  gnt,
    input  ack,
    input  reg_en,
    input  reg_in,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  lock,
    input  wdata,
    output gnt,
    output ack,
    output reg_en,
    output reg_in,
    output busy
  );

endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for a single shared register, with bounded
// locked bursts. All bus outputs are registered.
module shared_reg_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   hold_cnt;

  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               reg_en_q;
  logic [WIDTH-1:0]   reg_in_q;
  logic               busy_q;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic [IDX_W-1:0]   release_ptr;
  logic [IDX_W-1:0]   scan_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               hold_ok;
  int unsigned        pos;

  // Split the flat data bus into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Pointer after the current owner, and where this edge's scan starts.
  always_comb begin
    release_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    scan_ptr    = (state == GRANT) ? release_ptr : rr_ptr;
  end

  // Owner keeps the grant only while it still requests, locks, and has budget.
  always_comb begin
    hold_ok = (state == GRANT) && bus.req[owner] && bus.lock[owner] &&
              (hold_cnt < CNT_W'(MAX_HOLD));
  end

  // Round-robin scan: first requester at or after scan_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(scan_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!win_found && bus.req[IDX_W'(pos)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(pos);
      end
    end
  end

  // Grant FSM: hold a locked burst, otherwise release and re-arbitrate on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      reg_en_q <= 1'b0;
      reg_in_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          if (hold_ok) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            ack_q    <= gnt_q;
            reg_en_q <= 1'b1;
            reg_in_q <= data_arr[owner];
          end else begin
            rr_ptr <= release_ptr;
            if (win_found) begin
              state    <= GRANT;
              owner    <= win_idx;
              hold_cnt <= CNT_W'(1);
              gnt_q    <= NUM_REQ'(1) << win_idx;
              ack_q    <= NUM_REQ'(1) << win_idx;
              reg_en_q <= 1'b1;
              reg_in_q <= data_arr[win_idx];
              busy_q   <= 1'b1;
            end else begin
              state    <= IDLE;
              hold_cnt <= '0;
              gnt_q    <= '0;
              ack_q    <= '0;
              reg_en_q <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
        end
        default: begin
          if (win_found) begin
            state    <= GRANT;
            owner    <= win_idx;
            hold_cnt <= CNT_W'(1);
            gnt_q    <= NUM_REQ'(1) << win_idx;
            ack_q    <= NUM_REQ'(1) << win_idx;
            reg_en_q <= 1'b1;
            reg_in_q <= data_arr[win_idx];
            busy_q   <= 1'b1;
          end else begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            reg_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.reg_en = reg_en_q;
  assign bus.reg_in = reg_in_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic clk;
  logic rst;

  shared_reg_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  shared_reg_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model state: owner index (-1 = idle), burst count, scan pointer.
  int         m_owner;
  int         m_cnt;
  int         m_ptr;
  logic [7:0] m_regin;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        en;
    logic [7:0]  rin;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [3:0] g, input logic en, input logic [7:0] rin);
    check({nm, ".gnt"},    32'(bus.gnt),    32'(g));
    check({nm, ".ack"},    32'(bus.ack),    32'(g));
    check({nm, ".reg_en"}, 32'(bus.reg_en), 32'(en));
    check({nm, ".reg_in"}, 32'(bus.reg_in), 32'(rin));
    check({nm, ".busy"},   32'(bus.busy),   32'(g != 4'b0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = wd;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_regin = 8'h00;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_edge(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
    int cand;
    if (m_owner >= 0 && r[m_owner] && l[m_owner] && m_cnt < MH) begin
      m_cnt++;
      m_regin = wd[m_owner*8 +: 8];
    end else begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
      m_owner = -1;
      m_cnt   = 0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (m_owner < 0 && r[cand]) begin
          m_owner = cand;
          m_cnt   = 1;
          m_regin = wd[cand*8 +: 8];
        end
      end
    end
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  initial begin
    logic [3:0]  exp_seq [5];
    logic [3:0]  r;
    logic [3:0]  l;
    logic [31:0] wd;
    int          writes2;

    n_cmp = 0;
    n_err = 0;
    model_reset();

    // Round-robin, lock burst, single requester, idle, lock-without-req.
    tbl[0]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0001, 1'b1, 8'h10};
    tbl[1]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0010, 1'b1, 8'h11};
    tbl[2]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0100, 1'b1, 8'h12};
    tbl[3]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b1000, 1'b1, 8'h13};
    tbl[4]  = '{4'b1111, 4'b0000, 32'h13121110, 4'b0001, 1'b1, 8'h10};
    tbl[5]  = '{4'b0011, 4'b0001, 32'h13121120, 4'b0001, 1'b1, 8'h20};
    tbl[6]  = '{4'b0011, 4'b0001, 32'h13121130, 4'b0001, 1'b1, 8'h30};
    tbl[7]  = '{4'b0011, 4'b0001, 32'h13121140, 4'b0001, 1'b1, 8'h40};
    tbl[8]  = '{4'b0011, 4'b0001, 32'h13121150, 4'b0010, 1'b1, 8'h11};
    tbl[9]  = '{4'b0011, 4'b0001, 32'h13121160, 4'b0001, 1'b1, 8'h60};
    tbl[10] = '{4'b0011, 4'b0001, 32'h13121170, 4'b0001, 1'b1, 8'h70};
    tbl[11] = '{4'b0000, 4'b0000, 32'hFFFFFFFF, 4'b0000, 1'b0, 8'h70};
    tbl[12] = '{4'b0100, 4'b0000, 32'h13521110, 4'b0100, 1'b1, 8'h52};
    tbl[13] = '{4'b0100, 4'b0000, 32'h13661110, 4'b0100, 1'b1, 8'h66};
    tbl[14] = '{4'b0000, 4'b0000, 32'h13771110, 4'b0000, 1'b0, 8'h66};
    tbl[15] = '{4'b0000, 4'b1111, 32'h88888888, 4'b0000, 1'b0, 8'h66};

    // Reset with every requester asking.
    rst = 1'b1;
    drive(4'b1111, 4'b0000, 32'h13121110);
    step();
    step();
    check_all("reset", 4'b0000, 1'b0, 8'h00);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].wdata);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].en, tbl[i].rin);
    end

    // Requester 2 locked, drops req after two writes; grant moves to requester 3.
    writes2 = 0;
    drive(4'b0100, 4'b0100, 32'hA3A2A1A0);
    step();
    check_all("drop.w1", 4'b0100, 1'b1, 8'hA2);
    if (bus.reg_en && bus.ack[2]) writes2++;
    drive(4'b0100, 4'b0100, 32'hA3B2A1A0);
    step();
    check_all("drop.w2", 4'b0100, 1'b1, 8'hB2);
    if (bus.reg_en && bus.ack[2]) writes2++;
    drive(4'b1001, 4'b0100, 32'hC3C2C1C0);
    step();
    check_all("drop.move", 4'b1000, 1'b1, 8'hC3);
    if (bus.reg_en && bus.ack[2]) writes2++;
    check("drop.writes", 32'(writes2), 32'd2);
    drive(4'b0000, 4'b0000, 32'h0);
    step();
    check_all("drop.idle", 4'b0000, 1'b0, 8'hC3);

    // Move the pointer to 2 and start a burst, then reset mid-cycle.
    drive(4'b0010, 4'b0000, 32'h00001100);
    step();
    check_all("ptr.g1", 4'b0010, 1'b1, 8'h11);
    drive(4'b0100, 4'b0100, 32'h00220000);
    step();
    check_all("ptr.g2", 4'b0100, 1'b1, 8'h22);
    step();
    check_all("ptr.hold", 4'b0100, 1'b1, 8'h22);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 1'b0, 8'h00);

    // Arbitration restarts at 0 and hold count is fresh: four writes, then release.
    exp_seq[0] = 4'b0010;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0010;
    exp_seq[4] = 4'b0100;
    drive(4'b0110, 4'b0010, 32'h00443300);
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("post_rst%0d", i), exp_seq[i], 1'b1, (i == 4) ? 8'h44 : 8'h33);
    end

    // Randomized traffic against the reference model.
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0);
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      r  = 4'($urandom);
      l  = 4'($urandom) | 4'($urandom);
      wd = $urandom;
      if ((i % 50) > 40) r = 4'b0000;
      drive(r, l, wd);
      step();
      model_edge(r, l, wd);
      check_all($sformatf("rnd%0d", i), model_gnt(), m_owner >= 0, m_regin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
